// File: rtl/ram_ctrl.sv
// Single-port word RAM behind a fixed-latency request/response controller.
// A request is captured in IDLE and completes LATENCY cycles later; requests seen while busy are dropped.
module ram_ctrl #(
  parameter int SIZE_RAM  = 4096,
  parameter int ADDR_BITS = 12,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        mode,
  input  logic [31:0] address,
  input  logic [31:0] data,
  output logic [31:0] out,
  output logic        response,
  output logic        done
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  state_e                 r_state;
  state_e                 w_next_state;
  logic [7:0]             r_cnt;
  logic [ADDR_BITS-1:0]   r_idx;
  logic                   r_mode;
  logic [31:0]            r_data;
  logic [31:0]            r_out;
  logic                   r_resp;
  logic                   r_done;
  logic                   w_complete;
  logic [31:0]            r_mem [SIZE_RAM];

  assign w_complete = (r_state == BUSY) && (r_cnt == 8'd0);

  // NOTE: every register below uses non-blocking assignments so all state
  // updates on an edge see the pre-edge values of their neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  // NOTE: next-state defaults to the current state before the case so no path
  // leaves w_next_state unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (req)        w_next_state = BUSY;
      BUSY:    if (w_complete) w_next_state = IDLE;
      default:                 w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= 8'd0;
      r_out  <= 32'd0;
      r_resp <= 1'b0;
      r_done <= 1'b0;
      r_idx  <= '0;
      r_mode <= 1'b0;
      r_data <= 32'd0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (req) begin
          r_idx  <= address[ADDR_BITS-1:0];
          r_mode <= mode;
          r_data <= data;
          r_cnt  <= LAT_M1;
          r_resp <= 1'b1;
        end
      end else if (!w_complete) begin
        r_cnt <= r_cnt - 8'd1;
      end else begin
        // A write echoes the stored word so out always reflects mem after completion.
        r_out  <= r_mode ? r_data : r_mem[r_idx];
        r_resp <= 1'b0;
        r_done <= 1'b1;
      end
    end
  end

  // NOTE: the array has no reset branch on purpose; clearing thousands of words
  // in one edge is not buildable, and contents must survive rst_n anyway.
  // The rst_n gate only blocks a write that coincides with reset.
  always_ff @(posedge clk) begin
    if (rst_n && w_complete && r_mode) r_mem[r_idx] <= r_data;
  end

  assign out      = r_out;
  assign response = r_resp;
  assign done     = r_done;

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed bench for ram_ctrl: latency, read-after-write, wrap-around, busy drop,
// reset abort, and back-to-back behaviour of a LATENCY=1 instance.
module tb_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req, mode;
  logic [31:0] address, data;
  logic [31:0] out;
  logic        response, done;

  logic        req1, mode1;
  logic [31:0] address1, data1;
  logic [31:0] out1;
  logic        response1, done1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram_ctrl #(.SIZE_RAM(4096), .ADDR_BITS(12), .LATENCY(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .mode(mode), .address(address),
    .data(data), .out(out), .response(response), .done(done)
  );

  ram_ctrl #(.SIZE_RAM(4096), .ADDR_BITS(12), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .mode(mode1), .address(address1),
    .data(data1), .out(out1), .response(response1), .done(done1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request on the LATENCY=4 instance and follows it to completion.
  // Inputs are scrambled right after acceptance to show the operands are frozen.
  task automatic run_op(input string tag, input logic m, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_out);
    int lat = 0;
    int hi  = 0;
    mode = m; address = a; data = d; req = 1'b1;
    tick();
    req = 1'b0; mode = ~m; address = ~a; data = ~d;
    do begin
      if (response) hi++;
      tick();
      lat++;
    end while (!done && lat < 20);
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_resp_cycles"}, 32'(hi), 32'd4);
    check({tag, "_out"}, out, exp_out);
    check({tag, "_resp_low"}, {31'd0, response}, 32'd0);
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b1; mode = 1'b1; address = 32'd9; data = 32'h55;
    req1 = 1'b0; mode1 = 1'b0; address1 = 32'd0; data1 = 32'd0;
    tick(); tick();
    check("rst_resp", {31'd0, response}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out", out, 32'd0);
    rst_n = 1'b1; req = 1'b0;
    tick();
    check("rst_req_dropped", {31'd0, response}, 32'd0);

    run_op("rd5", 1'b0, 32'd5, 32'h0, 32'h0);
    run_op("wr10", 1'b1, 32'd10, 32'hDEADBEEF, 32'hDEADBEEF);
    run_op("rd10", 1'b0, 32'd10, 32'h0, 32'hDEADBEEF);
    run_op("wr4099", 1'b1, 32'd4099, 32'h12345678, 32'h12345678);
    run_op("rd3", 1'b0, 32'd3, 32'h0, 32'h12345678);

    // Idle with req low holds out.
    repeat (3) tick();
    check("idle_hold_out", out, 32'h12345678);
    check("idle_resp", {31'd0, response}, 32'd0);

    // req held high across the whole busy window: second request waits for T+5.
    mode = 1'b0; address = 32'd10; req = 1'b1;
    tick();
    address = 32'd3;
    repeat (3) tick();
    check("hold_busy_resp", {31'd0, response}, 32'd1);
    check("hold_busy_done", {31'd0, done}, 32'd0);
    tick();
    check("hold_first_done", {31'd0, done}, 32'd1);
    check("hold_first_out", out, 32'hDEADBEEF);
    check("hold_complete_ignored", {31'd0, response}, 32'd0);
    tick();
    check("hold_second_accept", {31'd0, response}, 32'd1);
    check("hold_second_nodone", {31'd0, done}, 32'd0);
    req = 1'b0;
    repeat (3) tick();
    check("hold_second_busy", {31'd0, done}, 32'd0);
    tick();
    check("hold_second_done", {31'd0, done}, 32'd1);
    check("hold_second_out", out, 32'h12345678);
    tick();

    // Reset two edges into a write aborts it; memory keeps its old value.
    mode = 1'b1; address = 32'd7; data = 32'hCAFEF00D; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("abort_out", out, 32'd0);
    check("abort_resp", {31'd0, response}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst_n = 1'b1;
    tick();
    check("abort_idle", {31'd0, response}, 32'd0);
    run_op("rd7", 1'b0, 32'd7, 32'h0, 32'h0);

    // LATENCY=1: req held high accepts on every other edge.
    mode1 = 1'b1; req1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      address1 = 32'(k);
      data1    = 32'h100 + 32'(k);
      tick();
      check($sformatf("l1_resp_%0d", k), {31'd0, response1}, {31'd0, ~k[0]});
      check($sformatf("l1_done_%0d", k), {31'd0, done1}, {31'd0, k[0]});
      if (k[0]) check($sformatf("l1_out_%0d", k), out1, 32'h100 + 32'(k - 1));
    end
    req1 = 1'b0;
    tick();
    mode1 = 1'b0; address1 = 32'd2; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    check("l1_rd_resp", {31'd0, response1}, 32'd1);
    tick();
    check("l1_rd_done", {31'd0, done1}, 32'd1);
    check("l1_rd_out", out1, 32'h102);
    tick();
    check("l1_rd_pulse", {31'd0, done1}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
